// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator driving 16 pins, each forced low, held high, or
// following the waveform; duty updates are taken only at period starts.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] LP_PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_pre_cnt;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_duty_shadow;
  logic [15:0] r_out;
  logic        r_period_start;

  logic        w_tick;
  logic        w_pstart;
  logic [7:0]  w_eff_duty;
  logic        w_pwm_raw;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;
  logic [15:0] w_out_next;

  assign w_tick     = (r_pre_cnt == LP_PRE_LAST);
  assign w_pstart   = (r_pre_cnt == 16'd0) && (r_pwm_cnt == 8'd0);
  // The duty input is used directly on the first step so the new value
  // governs the whole period it is latched for.
  assign w_eff_duty = w_pstart ? pwm_duty_cycle : r_duty_shadow;
  assign w_pwm_raw  = (w_eff_duty == 8'hFF) ? 1'b1 : (r_pwm_cnt < w_eff_duty);
  assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pin
      assign w_out_next[gi] = w_en_out[gi] & (~w_en_pwm[gi] | w_pwm_raw);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt      <= 16'd0;
      r_pwm_cnt      <= 8'd0;
      r_duty_shadow  <= 8'd0;
      r_out          <= 16'd0;
      r_period_start <= 1'b0;
    end else begin
      r_pre_cnt      <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      if (w_pstart) begin
        r_duty_shadow <= pwm_duty_cycle;
      end
      r_out          <= w_out_next;
      r_period_start <= w_pstart;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench: a PRESCALE=1 instance for cycle-exact waveform vectors and a
// PRESCALE=13 instance for the default timing and async reset.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out1, out13;
  logic        ps1, ps13;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  pwm_peripheral #(.PRESCALE(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out13), .period_start(ps13)
  );

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
    int          k;        // posedge index after reset release
    logic [15:0] exp_out;
    logic        exp_ps;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
    duty = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Leaves the bench 1 ns after a posedge with reset released; the next
  // posedge is cycle 1, which samples the period-start state.
  task automatic restart();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int hi_cnt;
    int ps_cnt;
    int bad_cnt;

    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h80,   1, 16'hFFFF, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 128, 16'hFFFF, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 129, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 256, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h80, 257, 16'hFFFF, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h00,   1, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h00, 200, 16'h0000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'hFF, 256, 16'hFFFF, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 8'hFF, 257, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h00F0, 16'h0030, 8'h40,   1, 16'h00F0, 1'b1});
    vecs.push_back('{16'h00F0, 16'h0030, 8'h40,  64, 16'h00F0, 1'b0});
    vecs.push_back('{16'h00F0, 16'h0030, 8'h40,  65, 16'h00C0, 1'b0});
    vecs.push_back('{16'h00F0, 16'h0030, 8'h40, 256, 16'h00C0, 1'b0});
    vecs.push_back('{16'h0000, 16'hFFFF, 8'h80,   1, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 8'h00,   5, 16'hFFFF, 1'b0});
    vecs.push_back('{16'hA5A5, 16'h0F0F, 8'h10,  16, 16'hA5A5, 1'b0});
    vecs.push_back('{16'hA5A5, 16'h0F0F, 8'h10,  17, 16'hA0A0, 1'b0});

    // Reset held with all inputs high: everything stays low.
    set_in(16'hFFFF, 16'hFFFF, 8'hFF);
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_out_p1", out1, 16'h0000);
    chk("reset_ps_p1", ps1, 1'b0);
    chk("reset_out_p13", out13, 16'h0000);
    chk("reset_ps_p13", ps13, 1'b0);
    rst_n = 1'b1;
    step();
    chk("release_ps_p1", ps1, 1'b1);
    chk("release_ps_p13", ps13, 1'b1);
    chk("release_out_p13", out13, 16'hFFFF);
    step();
    chk("release_ps_p13_c2", ps13, 1'b0);

    foreach (vecs[i]) begin
      set_in(vecs[i].eo, vecs[i].ep, vecs[i].d);
      restart();
      repeat (vecs[i].k) step();
      $display("vec %0d: eo=%h ep=%h duty=%h k=%0d out=%h ps=%b",
               i, vecs[i].eo, vecs[i].ep, vecs[i].d, vecs[i].k, out1, ps1);
      chk($sformatf("vec%0d_out", i), out1, vecs[i].exp_out);
      chk($sformatf("vec%0d_ps", i), ps1, vecs[i].exp_ps);
    end

    // 50% duty: 128 high cycles and one period_start per 256-cycle period.
    set_in(16'hFFFF, 16'hFFFF, 8'h80);
    restart();
    hi_cnt = 0;
    ps_cnt = 0;
    for (int k = 1; k <= 512; k++) begin
      step();
      if (out1 == 16'hFFFF) hi_cnt++;
      if (ps1) ps_cnt++;
    end
    chk("d80_high_cycles_2per", hi_cnt, 256);
    chk("d80_ps_count_2per", ps_cnt, 2);

    // 100% duty: no gap anywhere across two periods.
    set_in(16'hFFFF, 16'hFFFF, 8'hFF);
    restart();
    bad_cnt = 0;
    for (int k = 1; k <= 512; k++) begin
      step();
      if (out1 != 16'hFFFF) bad_cnt++;
    end
    chk("dFF_gap_cycles", bad_cnt, 0);

    // Mid-period duty write is deferred to the next period.
    set_in(16'hFFFF, 16'hFFFF, 8'h20);
    restart();
    hi_cnt = 0;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (out1 == 16'hFFFF) hi_cnt++;
      if (k == 80) duty = 8'hC0;
    end
    chk("shadow_cur_period_high", hi_cnt, 32);
    hi_cnt = 0;
    for (int k = 257; k <= 512; k++) begin
      step();
      if (k == 257) chk("shadow_next_ps", ps1, 1'b1);
      if (out1 == 16'hFFFF) hi_cnt++;
    end
    chk("shadow_next_period_high", hi_cnt, 192);

    // Enables are not shadowed: visible one clock after the change.
    set_in(16'hFFFF, 16'h0000, 8'h00);
    restart();
    repeat (10) step();
    chk("en_before", out1, 16'hFFFF);
    {eo_hi, eo_lo} = 16'h0F0F;
    chk("en_same_cycle", out1, 16'hFFFF);
    step();
    chk("en_after_1clk", out1, 16'h0F0F);

    // PRESCALE=13 timing, then async reset in the middle of the high phase.
    set_in(16'hFFFF, 16'hFFFF, 8'h80);
    restart();
    hi_cnt = 0;
    ps_cnt = 0;
    for (int k = 1; k <= 3328; k++) begin
      step();
      if (out13 == 16'hFFFF) hi_cnt++;
      if (ps13) ps_cnt++;
      if (k == 1664) chk("p13_last_high", out13, 16'hFFFF);
      if (k == 1665) chk("p13_first_low", out13, 16'h0000);
    end
    chk("p13_high_cycles", hi_cnt, 1664);
    chk("p13_ps_count", ps_cnt, 1);
    step();
    chk("p13_next_ps", ps13, 1'b1);
    repeat (100) step();
    chk("p13_mid_high", out13, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("p13_async_rst_out", out13, 16'h0000);
    chk("p13_async_rst_ps", ps13, 1'b0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
